acc_store_ctrl: RTL and testbench

ACC_STORE_CTRL -- requirements
Module: acc_store_ctrl

---
 rtl/acc_store_ctrl.sv | 173 +++++++++++++++++
 tb/tb_acc_store_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_store_ctrl.sv
// Accumulator store controller: queues {address, data} store requests and drives a
// handshaked memory write per entry. Define ACC_STORE_FIFO_EN for a 4-deep queue;
// otherwise a single holding register is used.
module acc_store_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] acc_in,
  output logic              st_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr,
  input  logic              mem_ack,
  output logic              st_done,
  output logic              st_err
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [3:0] WAIT_LAST = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              timeout;
  logic [ENT_W-1:0]  head;

  assign push    = st_req && !fifo_full;
  assign pop     = (state_q == S_IDLE) && !fifo_empty;
  assign timeout = (state_q == S_WRITE) && !mem_ack && (wait_q == WAIT_LAST);

`ifdef ACC_STORE_FIFO_EN
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic [ENT_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;

  // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo the depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {st_addr, acc_in};
  end

  assign fifo_full  = (occ_q == (PTR_W+1)'(DEPTH));
  assign fifo_empty = (occ_q == '0);
  assign head       = fifo_q[rd_ptr_q];
`else
  logic [ENT_W-1:0] hold_q;
  logic             occ_q, occ_d;

  // With one slot, push needs it empty and pop needs it full, so they never coincide.
  always_comb begin
    occ_d = occ_q;
    if (push) occ_d = 1'b1;
    if (pop)  occ_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= 1'b0;
    else     occ_q <= occ_d;
  end

  always_ff @(posedge clk) begin
    if (push) hold_q <= {st_addr, acc_in};
  end

  assign fifo_full  = occ_q;
  assign fifo_empty = !occ_q;
  assign head       = hold_q;
`endif

  assign st_busy = fifo_full;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (mem_ack)      state_d = S_DONE;
        else if (timeout) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_wr  = (state_q == S_WRITE);
    st_done = (state_q == S_DONE);
  end

  // Wait counter only runs while a write is outstanding; any other state clears it.
  always_comb begin
    wait_d = 4'd0;
    if ((state_q == S_WRITE) && !timeout) wait_d = wait_q + 4'd1;
    err_d = err_q || timeout || (st_req && fifo_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (pop) begin
      addr_q <= head[ENT_W-1:DATA_W];
      data_q <= head[DATA_W-1:0];
    end
  end

  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign st_err   = err_q;

endmodule

// File: tb/tb_acc_store_ctrl.sv
// Bench for acc_store_ctrl: directed scenarios plus random traffic, checked by a
// write scoreboard and a per-cycle status scoreboard fed from a queue-based model.
module tb_acc_store_ctrl;

`ifdef ACC_STORE_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk;
  logic        rst;
  logic        st_req;
  logic [12:0] st_addr;
  logic [7:0]  acc_in;
  logic        st_busy;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        mem_ack;
  logic        st_done;
  logic        st_err;

  acc_store_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .st_req   (st_req),
    .st_addr  (st_addr),
    .acc_in   (acc_in),
    .st_busy  (st_busy),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wr   (mem_wr),
    .mem_ack  (mem_ack),
    .st_done  (st_done),
    .st_err   (st_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          busy;
    bit          wr;
    bit          done;
    bit          err;
    logic [20:0] cur;
  } stat_t;

  int errors = 0;
  int checks = 0;

  logic [20:0] exp_wq[$];
  stat_t       stat_q[$];
  bit          drv_done = 0;

  // Reference model: a plain queue of pending stores plus the store being written.
  logic [20:0] m_q[$];
  bit          m_wr = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  int          m_cycles = 0;
  logic [20:0] m_cur = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, record the model's view of this cycle, advance the model.
  task automatic step(input bit req, input logic [12:0] a, input logic [7:0] d,
                      input bit r, input int ackmode);
    stat_t s;
    bit    ack;
    bit    flush;
    logic [20:0] e;
    case (ackmode)
      0:       ack = 1'b0;
      1:       ack = 1'b1;
      2:       ack = m_wr && (m_cycles >= 3);
      3:       ack = ($urandom_range(0, 1) == 1);
      default: ack = ($urandom_range(0, 15) == 0);
    endcase
    rst = r; st_req = req; st_addr = a; acc_in = d; mem_ack = ack;
    s.busy = (m_q.size() >= DEPTH);
    s.wr   = m_wr;
    s.done = m_done;
    s.err  = m_err;
    s.cur  = m_cur;
    stat_q.push_back(s);
    e = {a, d};
    flush = 0;
    if (r) begin
      m_q.delete(); m_wr = 0; m_done = 0; m_err = 0; m_cycles = 0; m_cur = '0;
      flush = 1;
    end else begin
      bit accept;
      accept = req && (m_q.size() < DEPTH);
      if (req && !accept) m_err = 1;
      if (m_wr) begin
        if (ack) begin m_wr = 0; m_done = 1; end
        else if (m_cycles == 15) begin m_wr = 0; m_err = 1; end
        else m_cycles++;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_q.size() > 0) begin
        m_cur = m_q.pop_front(); m_wr = 1; m_cycles = 1;
      end
      if (accept) begin m_q.push_back(e); exp_wq.push_back(e); end
    end
    @(posedge clk);
    #1;
    if (flush) exp_wq.delete();
  endtask

  task automatic idle(input int n, input int ackmode);
    for (int i = 0; i < n; i++) step(1'b0, 13'h0, 8'h0, 1'b0, ackmode);
  endtask

  initial begin
    rst = 1'b1; st_req = 1'b0; st_addr = '0; acc_in = '0; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    idle(0, 0);
    step(0, 13'h0, 8'h0, 1, 0);
    step(0, 13'h0, 8'h0, 1, 0);
    idle(2, 0);
    // single store with ack already high
    step(1, 13'h0A5, 8'h3C, 0, 1);
    idle(6, 1);
    // burst of four with delayed ack
    for (int i = 1; i <= 4; i++) step(1, 13'(16'h100 + i), 8'(i), 0, 2);
    idle(30, 2);
    // overflow with memory never acknowledging, then recovery
    for (int i = 0; i < 6; i++) step(1, 13'(16'h200 + i), 8'(8'h50 + i), 0, 0);
    idle(120, 0);
    step(1, 13'h1FFF, 8'hFF, 0, 1);
    idle(6, 1);
    // single timeout, then a serviced request
    step(0, 13'h0, 8'h0, 1, 0);
    step(1, 13'h0333, 8'hA5, 0, 0);
    idle(20, 0);
    step(1, 13'h0444, 8'h5A, 0, 1);
    idle(6, 1);
    // reset while a write is in flight with entries queued behind it
    for (int i = 0; i < 3; i++) step(1, 13'(16'h300 + i), 8'(8'h70 + i), 0, 0);
    idle(3, 0);
    step(0, 13'h0, 8'h0, 1, 0);
    idle(8, 1);
    // push coinciding with the pop of the only queued entry
    step(1, 13'h0011, 8'hC1, 0, 1);
    step(1, 13'h0022, 8'hC2, 0, 1);
    idle(10, 1);
    // random traffic
    for (int blk = 0; blk < 30; blk++) begin
      int am;
      int rate;
      am   = $urandom_range(1, 4);
      rate = $urandom_range(1, 6);
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(0, rate) == 0), 13'($urandom), 8'($urandom),
             ($urandom_range(0, 499) == 0), am);
      end
    end
    idle(60, 1);
    drv_done = 1;
  end

  // Monitor: compares DUT outputs against the recorded model view away from the active edge.
  initial begin
    bit    prev_wr;
    stat_t s;
    logic [20:0] e;
    prev_wr = 0;
    forever begin
      @(negedge clk);
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        chk("st_busy", 32'(st_busy), 32'(s.busy));
        chk("mem_wr", 32'(mem_wr), 32'(s.wr));
        chk("st_done", 32'(st_done), 32'(s.done));
        chk("st_err", 32'(st_err), 32'(s.err));
        chk("mem_addr", 32'(mem_addr), 32'(s.cur[20:8]));
        chk("mem_data", 32'(mem_data), 32'(s.cur[7:0]));
      end
      if (mem_wr === 1'b1 && !prev_wr) begin
        if (exp_wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_order: unexpected write addr %0h data %0h at %0t",
                   mem_addr, mem_data, $time);
        end else begin
          e = exp_wq.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(e[20:8]));
          chk("write_data", 32'(mem_data), 32'(e[7:0]));
        end
      end
      prev_wr = (mem_wr === 1'b1);
    end
  end

  initial begin
    fork
      begin
        wait (drv_done);
        @(negedge clk);
        @(negedge clk);
      end
      begin
        #2000000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected bench completion");
      end
    join_any
    chk("writes_drained", 32'(exp_wq.size()), 32'd0);
    chk("status_drained", 32'(stat_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
